// File: rtl/ram_dma_if.sv
// rtl/ram_dma_if.sv - RAM bus between the block-transfer initiator and the single-port RAM
interface ram_dma_if #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
);
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic                 mem_we;
  logic [DataWidth-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/ram_dma.sv
// rtl/ram_dma.sv - block COPY/FILL initiator for a single-port synchronous RAM
module ram_dma #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [AddrWidth-1:0] src_i,
  input  logic [AddrWidth-1:0] dst_i,
  input  logic [AddrWidth:0]   len_i,
  input  logic [DataWidth-1:0] fill_i,
  output logic                 busy_o,
  output logic                 done_o,
  ram_dma_if.master            mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;

  state_e               state_q;
  logic                 mode_q;
  logic [DataWidth-1:0] fill_q;
  logic [AddrWidth-1:0] src_ptr_q, dst_ptr_q;
  logic [AddrWidth:0]   cnt_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic                 mem_we_q;
  logic                 busy_q;
  logic                 done_q;

  logic [AddrWidth-1:0] src_ptr_d, dst_ptr_d;
  logic [AddrWidth:0]   cnt_d;
  logic                 last_word;

  assign src_ptr_d = src_ptr_q + {{(AddrWidth-1){1'b0}}, 1'b1};
  assign dst_ptr_d = dst_ptr_q + {{(AddrWidth-1){1'b0}}, 1'b1};
  assign cnt_d     = cnt_q - {{AddrWidth{1'b0}}, 1'b1};
  assign last_word = (cnt_q == {{AddrWidth{1'b0}}, 1'b1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_COPY;
      fill_q     <= '0;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          mem_we_q <= 1'b0;
          if (start_i) begin
            if (len_i == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              mode_q    <= mode_i;
              fill_q    <= fill_i;
              src_ptr_q <= src_i;
              dst_ptr_q <= dst_i;
              cnt_q     <= len_i;
              busy_q    <= 1'b1;
              if (mode_i == MODE_COPY) begin
                state_q    <= RD;
                mem_addr_q <= src_i;
              end else begin
                state_q    <= WR;
                mem_addr_q <= dst_i;
                mem_we_q   <= 1'b1;
              end
            end
          end
        end
        RD: begin
          state_q    <= WR;
          mem_addr_q <= dst_ptr_q;
          mem_we_q   <= 1'b1;
        end
        WR: begin
          src_ptr_q <= src_ptr_d;
          dst_ptr_q <= dst_ptr_d;
          cnt_q     <= cnt_d;
          if (last_word) begin
            state_q  <= FIN;
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (mode_q == MODE_COPY) begin
            state_q    <= RD;
            mem_addr_q <= src_ptr_d;
            mem_we_q   <= 1'b0;
          end else begin
            mem_addr_q <= dst_ptr_d;
            mem_we_q   <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // COPY forwards the word the RAM returns for the preceding RD address.
  assign mem.mem_wdata = (mode_q == MODE_COPY) ? mem.mem_rdata : fill_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_we    = mem_we_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_ram_dma.sv
// tb/tb_ram_dma.sv - directed self-checking bench for ram_dma against a behavioural RAM
module tb_ram_dma;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src = 8'h00;
  logic [7:0] dst = 8'h00;
  logic [8:0] len = 9'd0;
  logic [7:0] fill = 8'h00;
  logic       busy, done;

  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_data = 8'h00;
  logic [7:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  ram_dma_if #(.DataWidth(8), .AddrWidth(8)) bus ();

  ram_dma #(.DataWidth(8), .AddrWidth(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .mode_i  (mode),
    .src_i   (src),
    .dst_i   (dst),
    .len_i   (len),
    .fill_i  (fill),
    .busy_o  (busy),
    .done_o  (done),
    .mem     (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Cycle k counts negedges after the start cycle; a rogue FILL start is pulsed at cycle restart_at.
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] l, input logic [7:0] f,
                         input int restart_at, input int ncyc,
                         output int we_cnt, output int busy_cnt,
                         output int done_cnt, output int done_cyc);
    we_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill = f;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (bus.mem_we) we_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == restart_at) begin
        start = 1'b1; mode = 1'b1; src = 8'h00; dst = 8'h60; len = 9'd2; fill = 8'hEE;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_we got %0b want 0", bus.mem_we); end
    tests++; if (bus.mem_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want 00", bus.mem_addr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_len0_fill_all;
    int we_c, busy_c, done_c, done_k, bad;
    run_cmd(1'b1, 8'h00, 8'h00, 9'd0, 8'h77, 0, 4, we_c, busy_c, done_c, done_k);
    tests++; if (we_c !== 0) begin fails++; $display("FAIL len0_we got %0d want 0", we_c); end
    tests++; if (busy_c !== 0) begin fails++; $display("FAIL len0_busy got %0d want 0", busy_c); end
    tests++; if (done_k !== 1 || done_c !== 1) begin fails++; $display("FAIL len0_done got cyc %0d cnt %0d want 1 1", done_k, done_c); end
    run_cmd(1'b1, 8'h10, 8'h00, 9'd256, 8'hC3, 0, 260, we_c, busy_c, done_c, done_k);
    tests++; if (busy_c !== 256) begin fails++; $display("FAIL fill256_busy got %0d want 256", busy_c); end
    tests++; if (we_c !== 256) begin fails++; $display("FAIL fill256_we got %0d want 256", we_c); end
    tests++; if (done_k !== 257 || done_c !== 1) begin fails++; $display("FAIL fill256_done got cyc %0d cnt %0d want 257 1", done_k, done_c); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'hC3) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL fill256_data got %0d bad words want 0", bad); end
  endtask

  task automatic test_copy;
    int we_c, busy_c, done_c, done_k;
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
    for (int i = 0; i < 4; i++) bd_write(8'h10 + 8'(i), exp[i]);
    run_cmd(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, 0, 12, we_c, busy_c, done_c, done_k);
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[8'h80 + 8'(i)] !== exp[i]) begin fails++; $display("FAIL copy_data[%0d] got %h want %h", i, mem[8'h80 + 8'(i)], exp[i]); end
    end
    tests++; if (we_c !== 4) begin fails++; $display("FAIL copy_we got %0d want 4", we_c); end
    tests++; if (busy_c !== 8) begin fails++; $display("FAIL copy_busy got %0d want 8", busy_c); end
    tests++; if (done_k !== 9 || done_c !== 1) begin fails++; $display("FAIL copy_done got cyc %0d cnt %0d want 9 1", done_k, done_c); end
    tests++; if (mem[8'h84] !== 8'hC3) begin fails++; $display("FAIL copy_past_end got %h want c3", mem[8'h84]); end
  endtask

  task automatic test_fill_wrap;
    int we_c, busy_c, done_c, done_k;
    run_cmd(1'b1, 8'h00, 8'hFE, 9'd3, 8'h5A, 0, 6, we_c, busy_c, done_c, done_k);
    tests++; if (mem[8'hFE] !== 8'h5A) begin fails++; $display("FAIL wrap_fe got %h want 5a", mem[8'hFE]); end
    tests++; if (mem[8'hFF] !== 8'h5A) begin fails++; $display("FAIL wrap_ff got %h want 5a", mem[8'hFF]); end
    tests++; if (mem[8'h00] !== 8'h5A) begin fails++; $display("FAIL wrap_00 got %h want 5a", mem[8'h00]); end
    tests++; if (mem[8'h01] !== 8'hC3) begin fails++; $display("FAIL wrap_01 got %h want c3", mem[8'h01]); end
    tests++; if (we_c !== 3) begin fails++; $display("FAIL wrap_we got %0d want 3", we_c); end
    tests++; if (done_k !== 4 || done_c !== 1) begin fails++; $display("FAIL wrap_done got cyc %0d cnt %0d want 4 1", done_k, done_c); end
  endtask

  task automatic test_start_while_busy;
    int we_c, busy_c, done_c, done_k, bad;
    for (int i = 0; i < 8; i++) bd_write(8'h50 + 8'(i), 8'h30 + 8'(i));
    run_cmd(1'b0, 8'h50, 8'hA0, 9'd8, 8'h00, 5, 20, we_c, busy_c, done_c, done_k);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[8'hA0 + 8'(i)] !== 8'h30 + 8'(i)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL busy_start_data got %0d bad words want 0", bad); end
    tests++; if (mem[8'h60] !== 8'hC3) begin fails++; $display("FAIL busy_start_rogue got %h want c3", mem[8'h60]); end
    tests++; if (done_k !== 17 || done_c !== 1) begin fails++; $display("FAIL busy_start_done got cyc %0d cnt %0d want 17 1", done_k, done_c); end
    tests++; if (we_c !== 8) begin fails++; $display("FAIL busy_start_we got %0d want 8", we_c); end
  endtask

  task automatic test_reset_mid;
    int done_c, bad;
    for (int i = 0; i < 6; i++) bd_write(8'h40 + 8'(i), 8'h70 + 8'(i));
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src = 8'h40; dst = 8'h90; len = 9'd6; fill = 8'h00;
    @(negedge clk); start = 1'b0;
    for (int k = 2; k <= 8; k++) @(negedge clk);
    tests++; if (bus.mem_we !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_we got %0b want 1", bus.mem_we); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_mid_we got %0b want 0", bus.mem_we); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    done_c = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) done_c++; end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (done) done_c++; end
    tests++; if (done_c !== 0) begin fails++; $display("FAIL rst_mid_done got %0d want 0", done_c); end
    bad = 0;
    for (int i = 0; i < 3; i++) if (mem[8'h90 + 8'(i)] !== 8'h70 + 8'(i)) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL rst_mid_written got %0d bad words want 0", bad); end
    bad = 0;
    for (int i = 3; i < 6; i++) if (mem[8'h90 + 8'(i)] !== 8'hC3) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL rst_mid_untouched got %0d bad words want 0", bad); end
  endtask

  task automatic test_overlap;
    int we_c, busy_c, done_c, done_k;
    bd_write(8'h20, 8'h11);
    bd_write(8'h21, 8'h22);
    bd_write(8'h22, 8'h33);
    run_cmd(1'b0, 8'h20, 8'h21, 9'd3, 8'h00, 0, 10, we_c, busy_c, done_c, done_k);
    for (int i = 1; i <= 3; i++) begin
      tests++; if (mem[8'h20 + 8'(i)] !== 8'h11) begin fails++; $display("FAIL overlap[%0d] got %h want 11", i, mem[8'h20 + 8'(i)]); end
    end
    tests++; if (done_k !== 7 || done_c !== 1) begin fails++; $display("FAIL overlap_done got cyc %0d cnt %0d want 7 1", done_k, done_c); end
  endtask

  initial begin
    test_reset();
    test_len0_fill_all();
    test_copy();
    test_fill_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_overlap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
